memory_game_fsm: RTL and testbench
==================================

Name: memory_game_fsm

Overview:
- Simon-style memory game controller: shows a growing pseudo-random LED sequence on four LEDs, then checks the player's switch presses against it.
- Reports the running score, a win code and a lose code on o_Score.
- Sits between four debounced switch inputs and the board LED / 7-segment score display logic.

Parameters:
- CLKS_PER_SEC, default 25000000, clock cycles per second; sets LED display timing.
- GAME_LIMIT, default 6, number of rounds needed to win; legal range 1..11.

Ports:
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Switch_1  input  1  player switch 1; debounced, active-high.
- i_Switch_2  input  1  player switch 2; debounced, active-high.
- i_Switch_3  input  1  player switch 3; debounced, active-high.
- i_Switch_4  input  1  player switch 4; debounced, active-high.
- o_Score  output  8  score display code.
- o_LED_1  output  1  LED 1, active-high.
- o_LED_2  output  1  LED 2, active-high.
- o_LED_3  output  1  LED 3, active-high.
- o_LED_4  output  1  LED 4, active-high.

Behaviour:
- Reset (i_Rst_L=0, asynchronous):
  - state=START, score=0, o_Score=0, all LEDs 0.
  - LFSR loaded with nonzero seed 22'h1; all counters cleared.
- Switch presses:
  - Each switch is registered once per cycle.
  - A press is a rising edge: current=1 and previous=0. Pulse width is irrelevant; a one-cycle pulse counts.
- LFSR:
  - 22-bit maximal-length register (taps 22,21), free-running every cycle, never all-zero.
- Display time:
  - T = CLKS_PER_SEC/4 cycles, minimum 1.
- States:
  - START: LEDs off. When i_Switch_1 and i_Switch_2 are both high in the same cycle:
    - capture pattern = LFSR[2*GAME_LIMIT-1:0]; move k is bits [2k+1:2k], value 0..3 selects LED 1..4.
    - clear score and index; go to PATTERN_OFF.
  - PATTERN_OFF: all LEDs off for T cycles.
    - If index == score+1: clear index, go to WAIT_PLAYER.
    - Else go to PATTERN_SHOW.
  - PATTERN_SHOW: only the LED for move[index] is on for T cycles; then index++ and go to PATTERN_OFF.
  - WAIT_PLAYER: each LED mirrors its switch level.
    - No press: stay.
    - Exactly one switch pressed and it matches move[index]: index++. If the new index == score+1, go to INCR_SCORE.
    - Wrong switch, or two or more switches pressed in the same cycle: go to LOSER.
  - INCR_SCORE: score++ for one cycle. If the new score == GAME_LIMIT, go to WINNER; else clear index and go to PATTERN_OFF.
  - WINNER: o_Score=8'h0A, LEDs off.
  - LOSER: o_Score=8'h0F, LEDs off.
  - From WINNER or LOSER: i_Switch_1 and i_Switch_2 both high returns to START behaviour, i.e. a new pattern is captured and play restarts.
- o_Score:
  - Zero-extended score (0..GAME_LIMIT) in all states except WINNER and LOSER.
  - Registered, so it updates the cycle after the score or state changes.
- Round n (score=n-1) shows n moves, then expects n presses.
- No timeout in WAIT_PLAYER.
- Presses during PATTERN_SHOW or PATTERN_OFF are ignored.
- Reset mid-game returns immediately to START with score 0.

Decomposition:
- Package memory_game_pkg: state enum (START, PATTERN_OFF, PATTERN_SHOW, WAIT_PLAYER, INCR_SCORE, WINNER, LOSER); constants WIN_CODE=8'h0A, LOSE_CODE=8'h0F, LFSR_SEED.
- Sub-module game_lfsr (22-bit, async active-low reset, output full register).
- FSM, counters and pattern store live in memory_game_fsm.

Test Plan (CLKS_PER_SEC=5 so T=1, GAME_LIMIT=3):
- Reset, then no switches for 20 cycles -> state START, o_Score=0, all LEDs 0.
- One-cycle pulse on switches 1+2 together -> exactly one LED pulses (move 0); WAIT_PLAYER entered; o_Score=0.
- Correct press of move 0 -> score becomes 1 (o_Score=1); two LED pulses follow, showing move 0 then move 1.
- Complete 3 rounds with correct presses -> o_Score=8'h0A (WINNER); LEDs off.
- In round 1, press a wrong switch -> o_Score=8'h0F (LOSER). Separately, pressing two switches in one cycle -> o_Score=8'h0F.
- From LOSER press 1+2 -> new game, o_Score=0. Assert i_Rst_L low mid PATTERN_SHOW -> LEDs 0 and o_Score=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game controller.
package memory_game_pkg;

  typedef enum logic [2:0] {
    START        = 3'd0,
    PATTERN_OFF  = 3'd1,
    PATTERN_SHOW = 3'd2,
    WAIT_PLAYER  = 3'd3,
    INCR_SCORE   = 3'd4,
    WINNER       = 3'd5,
    LOSER        = 3'd6
  } state_e;

  localparam int unsigned      LFSR_W    = 22;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 22'h1;
  localparam logic [7:0]        WIN_CODE  = 8'h0A;
  localparam logic [7:0]        LOSE_CODE = 8'h0F;

  // Move value 0..3 selects LED/switch 1..4.
  function automatic logic [3:0] move_onehot(input logic [1:0] i_move);
    return 4'b0001 << i_move;
  endfunction

endpackage

// File: rtl/game_lfsr.sv
// Free-running 22-bit maximal-length LFSR (taps 22,21); never reaches all-zero.
module game_lfsr
  import memory_game_pkg::*;
(
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  output logic [LFSR_W-1:0] o_LFSR
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[21] ^ r_lfsr[20]};
  end

  assign o_LFSR = r_lfsr;

endmodule

// File: rtl/memory_game_fsm.sv
// Simon-style memory game: shows a growing LFSR-derived LED sequence, then
// checks the player's switch presses against it and reports score/win/lose.
module memory_game_fsm
  import memory_game_pkg::*;
#(
  parameter int unsigned CLKS_PER_SEC = 25000000,
  parameter int unsigned GAME_LIMIT   = 6
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic [7:0] o_Score,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4
);

  localparam int unsigned T_CYC = (CLKS_PER_SEC / 4 == 0) ? 1 : CLKS_PER_SEC / 4;
  localparam int unsigned CNT_W = (T_CYC > 1) ? $clog2(T_CYC) : 1;
  localparam int unsigned PAT_W = 2 * GAME_LIMIT;

  state_e             r_state, w_state_nxt;
  logic [3:0]         r_sw, r_sw_d, w_press;
  logic [PAT_W-1:0]   r_pattern, w_pattern_nxt;
  logic [3:0]         r_score, w_score_nxt;
  logic [3:0]         r_index, w_index_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [1:0]         w_move;
  logic [3:0]         w_move_1h;
  logic               w_start, w_timer_done;
  logic [LFSR_W-1:0]  w_lfsr;
  logic               w_unused_lfsr;
  logic [3:0]         r_led, w_led_nxt;
  logic [7:0]         r_score_out, w_score_out_nxt;

  game_lfsr u_lfsr (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .o_LFSR  (w_lfsr)
  );

  // Only the low bits seed the pattern; the rest just keep the sequence long.
  assign w_unused_lfsr = ^(w_lfsr >> PAT_W);

  assign w_press      = r_sw & ~r_sw_d;
  assign w_start      = r_sw[0] & r_sw[1];
  assign w_move       = 2'(r_pattern >> {r_index, 1'b0});
  assign w_move_1h    = move_onehot(w_move);
  assign w_timer_done = (r_cnt == CNT_W'(T_CYC - 1));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sw   <= '0;
      r_sw_d <= '0;
    end else begin
      r_sw   <= {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
      r_sw_d <= r_sw;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) r_state <= START;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_score_nxt   = r_score;
    w_index_nxt   = r_index;
    w_cnt_nxt     = '0;
    case (r_state)
      START, WINNER, LOSER: begin
        if (w_start) begin
          w_state_nxt   = PATTERN_OFF;
          w_pattern_nxt = w_lfsr[PAT_W-1:0];
          w_score_nxt   = '0;
          w_index_nxt   = '0;
        end
      end
      PATTERN_OFF: begin
        if (w_timer_done) begin
          if (r_index == r_score + 4'd1) begin
            w_state_nxt = WAIT_PLAYER;
            w_index_nxt = '0;
          end else begin
            w_state_nxt = PATTERN_SHOW;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PATTERN_SHOW: begin
        if (w_timer_done) begin
          w_state_nxt = PATTERN_OFF;
          w_index_nxt = r_index + 4'd1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      WAIT_PLAYER: begin
        // A multi-switch press never equals a one-hot move, so it loses too.
        if (w_press != 4'd0) begin
          if (w_press == w_move_1h) begin
            w_index_nxt = r_index + 4'd1;
            if (r_index == r_score) w_state_nxt = INCR_SCORE;
          end else begin
            w_state_nxt = LOSER;
          end
        end
      end
      INCR_SCORE: begin
        w_score_nxt = r_score + 4'd1;
        if (r_score == 4'(GAME_LIMIT - 1)) begin
          w_state_nxt = WINNER;
        end else begin
          w_state_nxt = PATTERN_OFF;
          w_index_nxt = '0;
        end
      end
      default: w_state_nxt = START;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_pattern <= '0;
      r_score   <= '0;
      r_index   <= '0;
      r_cnt     <= '0;
    end else begin
      r_pattern <= w_pattern_nxt;
      r_score   <= w_score_nxt;
      r_index   <= w_index_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_led_nxt       = '0;
    w_score_out_nxt = 8'(r_score);
    case (r_state)
      PATTERN_SHOW: w_led_nxt       = w_move_1h;
      WAIT_PLAYER:  w_led_nxt       = r_sw;
      WINNER:       w_score_out_nxt = WIN_CODE;
      LOSER:        w_score_out_nxt = LOSE_CODE;
      default:      w_led_nxt       = '0;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_led       <= '0;
      r_score_out <= '0;
    end else begin
      r_led       <= w_led_nxt;
      r_score_out <= w_score_out_nxt;
    end
  end

  assign o_Score = r_score_out;
  assign o_LED_1 = r_led[0];
  assign o_LED_2 = r_led[1];
  assign o_LED_3 = r_led[2];
  assign o_LED_4 = r_led[3];

endmodule

// File: tb/tb_memory_game_fsm.sv
// Randomized game play against a phase/queue-based model of the memory game.
module tb_memory_game_fsm;

  localparam int unsigned CPS = 5;
  localparam int unsigned GL  = 3;
  localparam int unsigned T   = (CPS / 4 == 0) ? 1 : CPS / 4;

  localparam int MD_IDLE  = 0;
  localparam int MD_SHOW  = 1;
  localparam int MD_INPUT = 2;
  localparam int MD_INCR  = 3;
  localparam int MD_WON   = 4;
  localparam int MD_LOST  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0, sw4 = 1'b0;
  logic [7:0] score;
  logic       led1, led2, led3, led4;

  int n_cmp = 0;
  int n_err = 0;

  memory_game_fsm #(.CLKS_PER_SEC(CPS), .GAME_LIMIT(GL)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Switch_1(sw1), .i_Switch_2(sw2), .i_Switch_3(sw3), .i_Switch_4(sw4),
    .o_Score(score),
    .o_LED_1(led1), .o_LED_2(led2), .o_LED_3(led3), .o_LED_4(led4)
  );

  always #5 clk = ~clk;

  // Model: a game phase, a queue of scripted display frames, and switch history.
  int          m_mode = MD_IDLE;
  logic [3:0]  m_q[$];
  logic [21:0] m_lfsr = 22'h1;
  logic [21:0] m_pat = '0;
  int          m_score = 0;
  int          m_idx = 0;
  logic [3:0]  m_cur = '0, m_prev = '0;
  logic [3:0]  exp_led;
  logic [7:0]  exp_score;
  logic [3:0]  press_v;

  function automatic int move_of(input int k);
    logic [21:0] s;
    s = m_pat >> (2 * k);
    return int'(s[1:0]);
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic build_round();
    m_q.delete();
    for (int k = 0; k <= m_score; k++) begin
      for (int t = 0; t < int'(T); t++) m_q.push_back(4'b0);
      for (int t = 0; t < int'(T); t++) m_q.push_back(4'(1 << move_of(k)));
    end
    for (int t = 0; t < int'(T); t++) m_q.push_back(4'b0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = MD_IDLE; m_q.delete(); m_lfsr = 22'h1; m_pat = '0;
      m_score = 0; m_idx = 0; m_cur = '0; m_prev = '0;
    end else begin
      exp_led   = 4'b0;
      exp_score = 8'(m_score);
      case (m_mode)
        MD_SHOW:  exp_led = m_q[0];
        MD_INPUT: exp_led = m_cur;
        MD_WON:   exp_score = 8'h0A;
        MD_LOST:  exp_score = 8'h0F;
        default:  exp_led = 4'b0;
      endcase
      press_v = m_cur & ~m_prev;
      case (m_mode)
        MD_IDLE, MD_WON, MD_LOST: begin
          if (m_cur[0] && m_cur[1]) begin
            m_pat = m_lfsr & 22'((1 << (2 * GL)) - 1);
            m_score = 0;
            build_round();
            m_mode = MD_SHOW;
          end
        end
        MD_SHOW: begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_mode = MD_INPUT; m_idx = 0; end
        end
        MD_INPUT: begin
          if (press_v != 4'b0) begin
            if (press_v == 4'(1 << move_of(m_idx))) begin
              m_idx++;
              if (m_idx == m_score + 1) m_mode = MD_INCR;
            end else m_mode = MD_LOST;
          end
        end
        MD_INCR: begin
          m_score++;
          if (m_score == int'(GL)) m_mode = MD_WON;
          else begin build_round(); m_mode = MD_SHOW; end
        end
        default: m_mode = MD_IDLE;
      endcase
      m_prev = m_cur;
      m_cur  = {sw4, sw3, sw2, sw1};
      m_lfsr = {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
      #1;
      if (rst_n) begin
        check("led_vs_model", {4'b0, led4, led3, led2, led1}, {4'b0, exp_led});
        check("score_vs_model", score, exp_score);
      end
    end
  end

  function automatic logic [3:0] leds();
    return {led4, led3, led2, led1};
  endfunction

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    {sw4, sw3, sw2, sw1} = v;
  endtask

  task automatic press(input logic [3:0] v);
    drive(v);
    repeat ($urandom_range(1)) drive(v);
    drive(4'b0);
    drive(4'b0);
  endtask

  task automatic wait_mode(input int md, input string nm);
    int i;
    for (i = 0; i < 60 && m_mode != md; i++) drive(4'b0);
    if (m_mode != md) begin
      n_cmp++; n_err++;
      $display("FAIL %s: phase %0d after wait, required %0d", nm, m_mode, md);
    end
  endtask

  task automatic wait_score(input logic [7:0] v, input string nm);
    for (int i = 0; i < 60 && score !== v; i++) drive(4'b0);
    check(nm, score, v);
  endtask

  task automatic start_game();
    drive(4'b0011);
    drive(4'b0);
  endtask

  task automatic play(input int p_wrong, input int p_two, input int p_noise);
    int budget = 600;
    int mv, a, b;
    logic [3:0] v;
    while (m_mode != MD_WON && m_mode != MD_LOST && budget > 0) begin
      budget--;
      if (m_mode == MD_INPUT) begin
        mv = move_of(m_idx);
        if (int'($urandom_range(99)) < p_wrong)
          v = 4'(1 << ((mv + 1 + int'($urandom_range(2))) % 4));
        else if (int'($urandom_range(99)) < p_two) begin
          a = int'($urandom_range(3));
          b = (a + 1 + int'($urandom_range(2))) % 4;
          v = 4'((1 << a) | (1 << b));
        end else v = 4'(1 << mv);
        repeat ($urandom_range(1)) drive(4'b0);
        press(v);
      end else if (int'($urandom_range(99)) < p_noise) begin
        press(4'(1 << $urandom_range(3)));
      end else drive(4'b0);
    end
    if (budget == 0) begin
      n_cmp++; n_err++;
      $display("FAIL game_timeout: phase %0d, required a finished game", m_mode);
    end
  endtask

  int   pulses, max_ones;
  logic [3:0] prev_l;
  logic found;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) drive(4'b0);
    check("idle_score", score, 8'h00);
    check("idle_leds", {4'b0, leds()}, 8'h00);

    // Round 1: exactly one single-LED pulse, then waiting at score 0.
    drive(4'b0011);
    pulses = 0; max_ones = 0; prev_l = 4'b0;
    repeat (8) begin
      drive(4'b0);
      if (leds() != 4'b0 && prev_l == 4'b0) pulses++;
      if ($countones(leds()) > max_ones) max_ones = $countones(leds());
      prev_l = leds();
    end
    check("r1_pulse_count", 8'(pulses), 8'd1);
    check("r1_onehot", 8'(max_ones), 8'd1);
    check("r1_score", score, 8'h00);

    // Correct press -> score 1, then two pulses for round 2.
    press(4'(1 << move_of(0)));
    wait_score(8'h01, "score_after_r1");
    pulses = 0; prev_l = 4'b0;
    repeat (10) begin
      drive(4'b0);
      if (leds() != 4'b0 && prev_l == 4'b0) pulses++;
      prev_l = leds();
    end
    check("r2_pulse_count", 8'(pulses), 8'd2);

    play(0, 0, 0);
    wait_score(8'h0A, "win_code");
    check("win_leds", {4'b0, leds()}, 8'h00);

    // Wrong switch in round 1.
    start_game();
    wait_mode(MD_INPUT, "wait_r1_wrong");
    press(4'(1 << ((move_of(0) + 1 + int'($urandom_range(2))) % 4)));
    wait_score(8'h0F, "lose_wrong");

    // Restart from LOSER, then two switches at once.
    start_game();
    wait_score(8'h00, "restart_score");
    wait_mode(MD_INPUT, "wait_r1_two");
    press(4'b1100);
    wait_score(8'h0F, "lose_two");
    check("lose_leds", {4'b0, leds()}, 8'h00);

    for (int g = 0; g < 40; g++) begin
      start_game();
      play(8, 6, 10);
      repeat (2) drive(4'b0);
    end

    // Asynchronous reset while round 2 is on display.
    start_game();
    wait_mode(MD_INPUT, "wait_r1_reset");
    press(4'(1 << move_of(0)));
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (score == 8'h01 && leds() != 4'b0) found = 1'b1;
    end
    check("pre_reset_led_on", 8'(found), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_leds", {4'b0, leds()}, 8'h00);
    check("async_rst_score", score, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) drive(4'b0);
    check("post_rst_score", score, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
